// File: rtl/divider.sv
// Sequential RV32M divide unit for DIV/DIVU/REM/REMU. It is a radix-2 restoring divider that retires one quotient bit per cycle.
// Define FPGA_DIVIDER_EN to select a single-cycle native-operator datapath instead.
module divider (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic [1:0]  DIVop,
  input  logic        valid,
  output logic [31:0] result,
  output logic        ready
);

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_CALC  = 3'b010;
  localparam logic [2:0] S_READY = 3'b100;

  // Negate only when the op is signed and the operand is negative.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      abs32 = 32'd0 - v;
    end else begin
      abs32 = v;
    end
  endfunction

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    if (neg) begin
      cond_neg32 = 32'd0 - v;
    end else begin
      cond_neg32 = v;
    end
  endfunction

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] raw_q, raw_d;
  logic [31:0] quo_q, quo_d;
  logic [32:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        zero_q, zero_d;
  logic [31:0] result_q, result_d;
  logic        ready_q, ready_d;
`ifndef FPGA_DIVIDER_EN
  logic [33:0] rem_shift;
  logic [33:0] rem_diff;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Illegal one-hot encodings fall back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          if (divisor == 32'd0) begin
            state_d = S_READY;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
`ifdef FPGA_DIVIDER_EN
        state_d = S_READY;
`else
        if (cnt_q == 5'd31) begin
          state_d = S_READY;
        end else begin
          state_d = S_CALC;
        end
`endif
      end
      S_READY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, per-cycle divide step, and result correction.
  always_comb begin
    op_d      = op_q;
    dvsr_d    = dvsr_q;
    raw_d     = raw_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    result_d  = result_q;
    ready_d   = 1'b0;
`ifndef FPGA_DIVIDER_EN
    rem_shift = 34'd0;
    rem_diff  = 34'd0;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          op_d      = DIVop;
          dvsr_d    = abs32(divisor, ~DIVop[0]);
          quo_d     = abs32(dividend, ~DIVop[0]);
          raw_d     = dividend;
          neg_quo_d = ~DIVop[0] & (dividend[31] ^ divisor[31]);
          neg_rem_d = ~DIVop[0] & dividend[31];
          zero_d    = (divisor == 32'd0);
          if (divisor == 32'd0) begin
            rem_d = rem_q;
            cnt_d = cnt_q;
          end else begin
            rem_d = 33'd0;
            cnt_d = 5'd0;
          end
        end else begin
          op_d = op_q;
        end
      end
      S_CALC: begin
`ifdef FPGA_DIVIDER_EN
        quo_d = quo_q / dvsr_q;
        rem_d = {1'b0, quo_q % dvsr_q};
`else
        rem_shift = {rem_q, quo_q[31]};
        rem_diff  = rem_shift - {2'b00, dvsr_q};
        if (!rem_diff[33]) begin
          rem_d = rem_diff[32:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift[32:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
`endif
        cnt_d = cnt_q + 5'd1;
      end
      S_READY: begin
        ready_d = 1'b1;
        // Division by zero returns all ones for quotients and the untouched dividend for remainders.
        if (zero_q) begin
          if (op_q == DIV_OP_REM || op_q == DIV_OP_REMU) begin
            result_d = raw_q;
          end else begin
            result_d = 32'hFFFF_FFFF;
          end
        end else if (op_q == DIV_OP_DIV || op_q == DIV_OP_DIVU) begin
          result_d = cond_neg32(quo_q, neg_quo_q & ~op_q[0]);
        end else begin
          result_d = cond_neg32(rem_q[31:0], neg_rem_q & ~op_q[0]);
        end
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= 2'b00;
      dvsr_q    <= 32'd0;
      raw_q     <= 32'd0;
      quo_q     <= 32'd0;
      rem_q     <= 33'd0;
      cnt_q     <= 5'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      result_q  <= 32'd0;
      ready_q   <= 1'b0;
    end else begin
      op_q      <= op_d;
      dvsr_q    <= dvsr_d;
      raw_q     <= raw_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed ISA cases, reset abort, back-to-back issue with input scrambling, and random ops vs a reference model.
module tb_divider;

  logic        clk;
  logic        reset;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [1:0]  DIVop;
  logic        valid;
  logic [31:0] result;
  logic        ready;

  int errors = 0;
  int checks = 0;

`ifdef FPGA_DIVIDER_EN
  localparam int LAT_NORM = 3;
`else
  localparam int LAT_NORM = 34;
`endif
  localparam int LAT_ZERO = 2;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expv;
  } vec_t;

  vec_t vecs [12];

  divider dut (
    .clk      (clk),
    .reset    (reset),
    .dividend (dividend),
    .divisor  (divisor),
    .DIVop    (DIVop),
    .valid    (valid),
    .result   (result),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RV32M semantics computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0] == 1'b0) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return op[1] ? r[31:0] : q[31:0];
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
    return (b == 32'd0) ? LAT_ZERO : LAT_NORM;
  endfunction

  function automatic logic [31:0] pick_operand();
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and return the result plus the number of cycles until ready is seen (-1 on timeout).
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit no_wait, input bit scramble,
                       output logic [31:0] res, output int lat);
    if (!no_wait) @(negedge clk);
    dividend = a;
    divisor  = b;
    DIVop    = op;
    valid    = 1'b1;
    @(posedge clk);
    lat = -1;
    res = 32'bx;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      valid = 1'b0;
      if (scramble) begin
        dividend = $urandom;
        divisor  = $urandom;
        DIVop    = 2'($urandom);
      end
      if (ready === 1'b1) begin
        lat = n;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    valid    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    DIVop    = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL reset ready: got %b expected 0", ready);
    end
    checks++;
    if (result !== 32'd0) begin
      errors++;
      $display("FAIL reset result: got %h expected 00000000", result);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] r;
    int          l;
    vecs[0]  = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    vecs[1]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[2]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFF};
    vecs[3]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vecs[4]  = '{2'b01, 32'd100,       32'd7,         32'd14};
    vecs[5]  = '{2'b11, 32'd100,       32'd7,         32'd2};
    vecs[6]  = '{2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[7]  = '{2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
    vecs[8]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[9]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[10] = '{2'b01, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[11] = '{2'b11, 32'd7,         32'd0,         32'd7};
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, r, l);
      checks++;
      if (r !== vecs[i].expv) begin
        errors++;
        $display("FAIL directed[%0d] result: got %h expected %h", i, r, vecs[i].expv);
      end
      checks++;
      if (l != exp_lat(vecs[i].b)) begin
        errors++;
        $display("FAIL directed[%0d] latency: got %0d expected %0d", i, l, exp_lat(vecs[i].b));
      end
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL directed[%0d] pulse width: ready got %b expected 0", i, ready);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r;
    int          l;
    int          pulses;
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd3;
    DIVop    = 2'b01;
    valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset ready: got %b expected 0", ready);
    end
    checks++;
    if (result !== 32'd0) begin
      errors++;
      $display("FAIL midreset result: got %h expected 00000000", result);
    end
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midreset stray pulse: got %0d pulses expected 0", pulses);
    end
    do_op(2'b01, 32'd9, 32'd4, 1'b1, 1'b0, r, l);
    checks++;
    if (r !== 32'd2) begin
      errors++;
      $display("FAIL midreset followup result: got %h expected 00000002", r);
    end
    checks++;
    if (l != LAT_NORM) begin
      errors++;
      $display("FAIL midreset followup latency: got %0d expected %0d", l, LAT_NORM);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, r1, r2;
    logic [1:0]  op1, op2;
    int          l1, l2;
    for (int i = 0; i < 4; i++) begin
      op1 = 2'($urandom);
      a1  = $urandom;
      b1  = $urandom;
      op2 = 2'($urandom);
      a2  = $urandom;
      b2  = (i == 2) ? 32'd0 : $urandom;
      do_op(op1, a1, b1, 1'b0, 1'b1, r1, l1);
      do_op(op2, a2, b2, 1'b1, 1'b1, r2, l2);
      checks++;
      if (r1 !== ref_result(op1, a1, b1)) begin
        errors++;
        $display("FAIL b2b[%0d] first result: got %h expected %h", i, r1, ref_result(op1, a1, b1));
      end
      checks++;
      if (l1 != exp_lat(b1)) begin
        errors++;
        $display("FAIL b2b[%0d] first latency: got %0d expected %0d", i, l1, exp_lat(b1));
      end
      checks++;
      if (r2 !== ref_result(op2, a2, b2)) begin
        errors++;
        $display("FAIL b2b[%0d] second result: got %h expected %h", i, r2, ref_result(op2, a2, b2));
      end
      checks++;
      if (l2 != exp_lat(b2)) begin
        errors++;
        $display("FAIL b2b[%0d] second latency: got %0d expected %0d", i, l2, exp_lat(b2));
      end
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d] pulse width: ready got %b expected 0", i, ready);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r;
    logic [1:0]  op;
    int          l;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      do_op(op, a, b, 1'b0, 1'b0, r, l);
      checks++;
      if (r !== ref_result(op, a, b)) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, r, ref_result(op, a, b));
      end
      checks++;
      if (l != exp_lat(b)) begin
        errors++;
        $display("FAIL random[%0d] latency: got %0d expected %0d", i, l, exp_lat(b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
